// File: rtl/alu_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_branch_ctrl
// Description : Multi-cycle initiator for an external 32-bit ALU. Accepts one
//               operation per request, drives the ALU for a single EXEC cycle,
//               captures result/flags, resolves branches and computes the
//               next PC, then holds a response until it is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_branch_ctrl #(
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned BR_SHIFT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // request port
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_opcode,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [31:0]      req_pc,
  input  logic [31:0]      req_imm,
  // ALU interface
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  // response port
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_taken,
  output logic [31:0]      rsp_next_pc,
  output logic             rsp_illegal,
  // performance counters
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] taken_count
);

  // Opcode map
  localparam logic [5:0] OP_AND   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_ANDI  = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd4;
  localparam logic [5:0] OP_BGT   = 6'd8;
  localparam logic [5:0] OP_BLT   = 6'd9;
  localparam logic [5:0] OP_BEQ   = 6'd10;
  localparam logic [5:0] OP_BNE   = 6'd11;
  // Opcode presented to the ALU whenever it is not being used
  localparam logic [5:0] OP_IDLE  = 6'h3F;
  // Flags reported for an illegal opcode: {C,Z,N,V} with only Z set
  localparam logic [3:0] ILLEGAL_FLAGS = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q,       state_d;
  logic [5:0]       opcode_q,      opcode_d;
  logic [31:0]      src1_q,        src1_d;
  logic [31:0]      src2_q,        src2_d;
  logic [31:0]      pc_q,          pc_d;
  logic [31:0]      imm_q,         imm_d;
  logic [31:0]      result_q,      result_d;
  logic [3:0]       flags_q,       flags_d;
  logic             taken_q,       taken_d;
  logic [31:0]      next_pc_q,     next_pc_d;
  logic             illegal_q,     illegal_d;
  logic [CNT_W-1:0] op_count_q,    op_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  // Decode of the registered opcode
  logic        is_logic;
  logic        is_branch;
  logic        is_legal;
  // Captured flag view after masking, and the branch decision built from it
  logic [3:0]  flags_eff;
  logic        c_f, z_f, n_f, v_f;
  logic        branch_cond;
  logic [31:0] target_pc;
  logic [31:0] fall_pc;

  // Classify the in-flight opcode
  always_comb begin
    is_logic  = 1'b0;
    is_branch = 1'b0;
    is_legal  = 1'b0;
    case (opcode_q)
      OP_AND, OP_ANDI: begin
        is_logic = 1'b1;
        is_legal = 1'b1;
      end
      OP_ADD, OP_SUB, OP_ADDI: begin
        is_legal = 1'b1;
      end
      OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
        is_branch = 1'b1;
        is_legal  = 1'b1;
      end
      default: begin
        is_legal = 1'b0;
      end
    endcase
  end

  // Mask ALU flags (logic ops never report carry/overflow) and resolve branch
  always_comb begin
    flags_eff = {alu_carry, alu_zero, alu_negative, alu_overflow};
    if (!is_legal) begin
      flags_eff = ILLEGAL_FLAGS;
    end else if (is_logic) begin
      flags_eff = {1'b0, alu_zero, alu_negative, 1'b0};
    end
    {c_f, z_f, n_f, v_f} = flags_eff;

    branch_cond = 1'b0;
    case (opcode_q)
      OP_BGT:  branch_cond = ~z_f & (n_f == v_f);
      OP_BLT:  branch_cond = (n_f != v_f);
      OP_BEQ:  branch_cond = z_f;
      OP_BNE:  branch_cond = ~z_f;
      default: branch_cond = 1'b0;
    endcase
    // Carry is part of the reported flags but plays no role in branching
    branch_cond = branch_cond & is_branch & (c_f | ~c_f);

    // Both PC candidates wrap modulo 2^32
    target_pc = pc_q + (imm_q << BR_SHIFT);
    fall_pc   = pc_q + 32'(PC_STEP);
  end

  // Next-state, capture and counter logic
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    result_d      = result_q;
    flags_d       = flags_q;
    taken_d       = taken_q;
    next_pc_d     = next_pc_q;
    illegal_d     = illegal_q;
    op_count_d    = op_count_q;
    taken_count_d = taken_count_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          opcode_d = req_opcode;
          src1_d   = req_src1;
          src2_d   = req_src2;
          pc_d     = req_pc;
          imm_d    = req_imm;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d  = is_legal ? alu_result : 32'd0;
        flags_d   = flags_eff;
        taken_d   = branch_cond;
        next_pc_d = branch_cond ? target_pc : fall_pc;
        illegal_d = ~is_legal;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          if (taken_q) begin
            taken_count_d = taken_count_q + CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and response registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      opcode_q      <= OP_IDLE;
      src1_q        <= 32'd0;
      src2_q        <= 32'd0;
      pc_q          <= 32'd0;
      imm_q         <= 32'd0;
      result_q      <= 32'd0;
      flags_q       <= 4'd0;
      taken_q       <= 1'b0;
      next_pc_q     <= 32'd0;
      illegal_q     <= 1'b0;
      op_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      result_q      <= result_d;
      flags_q       <= flags_d;
      taken_q       <= taken_d;
      next_pc_q     <= next_pc_d;
      illegal_q     <= illegal_d;
      op_count_q    <= op_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  // ALU lines are only live during EXEC; otherwise parked at zero / 6'h3F
  always_comb begin
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    alu_opcode = OP_IDLE;
    if (state_q == EXEC) begin
      alu_a      = src1_q;
      alu_b      = src2_q;
      alu_opcode = opcode_q;
    end
  end

  // Handshake and response outputs
  always_comb begin
    req_ready   = (state_q == IDLE);
    rsp_valid   = (state_q == RESP);
    rsp_result  = result_q;
    rsp_flags   = flags_q;
    rsp_taken   = taken_q;
    rsp_next_pc = next_pc_q;
    rsp_illegal = illegal_q;
    op_count    = op_count_q;
    taken_count = taken_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_branch_ctrl
// Description : Directed self-checking bench for alu_branch_ctrl with a small
//               behavioural ALU attached to the ALU port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_branch_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_opcode;
  logic [31:0]      req_src1;
  logic [31:0]      req_src2;
  logic [31:0]      req_pc;
  logic [31:0]      req_imm;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [5:0]       alu_opcode;
  logic [31:0]      alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_negative;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_taken;
  logic [31:0]      rsp_next_pc;
  logic             rsp_illegal;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] taken_count;

  int checks;
  int errors;

  alu_branch_ctrl #(
    .PC_STEP  (4),
    .BR_SHIFT (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .req_pc       (req_pc),
    .req_imm      (req_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_taken    (rsp_taken),
    .rsp_next_pc  (rsp_next_pc),
    .rsp_illegal  (rsp_illegal),
    .op_count     (op_count),
    .taken_count  (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU. Branches compare via subtraction; SUB carry is the
  // borrow. Logic ops report C=V=1 on purpose so flag masking is observable.
  always_comb begin
    logic [32:0] wide;
    wide         = 33'd0;
    alu_result   = 32'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      6'd0, 6'd3: begin
        alu_result   = alu_a & alu_b;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
      end
      6'd1, 6'd4: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[31:0];
        alu_carry    = wide[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      6'd2, 6'd8, 6'd9, 6'd10, 6'd11: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      default: begin
        alu_result = 32'hDEAD_BEEF;
      end
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request in the current cycle; returns #1 after the accepting edge
  task automatic send(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] pc, input logic [31:0] imm);
    req_valid  = 1'b1;
    req_opcode = op;
    req_src1   = s1;
    req_src2   = s2;
    req_pc     = pc;
    req_imm    = imm;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  // Advance one clock, sampling #1 after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume the pending response with a one-cycle rsp_ready pulse
  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = 6'd0;
    req_src1   = 32'd0;
    req_src2   = 32'd0;
    req_pc     = 32'd0;
    req_imm    = 32'd0;
    rsp_ready  = 1'b0;

    // ---- reset state
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'h3F);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_next_pc", rsp_next_pc, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_taken_count", 32'(taken_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- ADD overflow; response visible after the EXEC cycle
    send(6'd1, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("add_exec_valid", 32'(rsp_valid), 32'd0);
    chk("add_exec_ready", 32'(req_ready), 32'd0);
    chk("add_exec_aluop", 32'(alu_opcode), 32'd1);
    chk("add_exec_alu_a", alu_a, 32'h7FFF_FFFF);
    chk("add_exec_alu_b", alu_b, 32'd1);
    tick();
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", rsp_result, 32'h8000_0000);
    chk("add_flags", 32'(rsp_flags), 32'b0011);
    chk("add_taken", 32'(rsp_taken), 32'd0);
    chk("add_next_pc", rsp_next_pc, 32'd4);
    chk("add_resp_aluop", 32'(alu_opcode), 32'h3F);
    consume();
    chk("add_done_valid", 32'(rsp_valid), 32'd0);
    chk("add_done_ready", 32'(req_ready), 32'd1);
    chk("add_op_count", 32'(op_count), 32'd1);
    chk("add_taken_count", 32'(taken_count), 32'd0);

    // ---- BGT taken: 5 > -3
    send(6'd8, 32'd5, 32'hFFFF_FFFD, 32'h100, 32'h10);
    tick();
    chk("bgt_taken", 32'(rsp_taken), 32'd1);
    chk("bgt_next_pc", rsp_next_pc, 32'h140);
    consume();
    chk("bgt_taken_count", 32'(taken_count), 32'd1);
    chk("bgt_op_count", 32'(op_count), 32'd2);

    // ---- BLT not taken: 5 < 5 false, zero set
    send(6'd9, 32'd5, 32'd5, 32'h200, 32'h10);
    tick();
    chk("blt_flags", 32'(rsp_flags), 32'b0100);
    chk("blt_taken", 32'(rsp_taken), 32'd0);
    chk("blt_next_pc", rsp_next_pc, 32'h204);
    consume();
    chk("blt_taken_count", 32'(taken_count), 32'd1);

    // ---- BNE taken with signed overflow, target wraps downward
    send(6'd11, 32'h8000_0000, 32'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    tick();
    chk("bne_flags", 32'(rsp_flags), 32'b0001);
    chk("bne_taken", 32'(rsp_taken), 32'd1);
    chk("bne_next_pc", rsp_next_pc, 32'hFFFF_FFF8);
    consume();
    chk("bne_taken_count", 32'(taken_count), 32'd2);

    // ---- BEQ not taken, fall-through PC wraps to zero
    send(6'd10, 32'h8000_0000, 32'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    tick();
    chk("beq_taken", 32'(rsp_taken), 32'd0);
    chk("beq_next_pc", rsp_next_pc, 32'h0000_0000);
    consume();
    chk("beq_op_count", 32'(op_count), 32'd5);

    // ---- overflowing ADD then ANDI with C/V masked, backpressure held
    send(6'd1, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    tick();
    chk("add2_flags", 32'(rsp_flags), 32'b0011);
    consume();
    send(6'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h40, 32'd0);
    tick();
    // Second request offered while the ANDI response is stalled
    req_valid  = 1'b1;
    req_opcode = 6'd1;
    req_src1   = 32'd1;
    req_src2   = 32'd2;
    req_pc     = 32'h80;
    req_imm    = 32'd0;
    for (int i = 0; i < 3; i++) begin
      chk("andi_hold_valid", 32'(rsp_valid), 32'd1);
      chk("andi_hold_result", rsp_result, 32'd0);
      chk("andi_hold_flags", 32'(rsp_flags), 32'b0100);
      chk("andi_hold_next_pc", rsp_next_pc, 32'h44);
      chk("andi_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // Handshake edge: pending request must not have been taken in this edge
    chk("andi_hs_valid", 32'(rsp_valid), 32'd0);
    chk("andi_hs_ready", 32'(req_ready), 32'd1);
    chk("andi_hs_aluop", 32'(alu_opcode), 32'h3F);
    chk("andi_op_count", 32'(op_count), 32'd7);
    tick();
    req_valid = 1'b0;
    chk("pend_exec_aluop", 32'(alu_opcode), 32'd1);
    chk("pend_exec_ready", 32'(req_ready), 32'd0);
    tick();
    chk("pend_result", rsp_result, 32'd3);
    chk("pend_flags", 32'(rsp_flags), 32'b0000);
    chk("pend_next_pc", rsp_next_pc, 32'h84);
    consume();
    chk("pend_op_count", 32'(op_count), 32'd8);

    // ---- illegal opcode
    send(6'h07, 32'h1234_5678, 32'h1, 32'h300, 32'h10);
    chk("ill_exec_aluop", 32'(alu_opcode), 32'h07);
    tick();
    chk("ill_resp_aluop", 32'(alu_opcode), 32'h3F);
    chk("ill_illegal", 32'(rsp_illegal), 32'd1);
    chk("ill_result", rsp_result, 32'd0);
    chk("ill_flags", 32'(rsp_flags), 32'b0100);
    chk("ill_taken", 32'(rsp_taken), 32'd0);
    chk("ill_next_pc", rsp_next_pc, 32'h304);
    consume();
    chk("ill_op_count", 32'(op_count), 32'd9);
    chk("ill_taken_count", 32'(taken_count), 32'd2);

    // ---- reset during EXEC discards the operation
    send(6'd1, 32'd10, 32'd20, 32'h500, 32'd0);
    chk("rexec_aluop", 32'(alu_opcode), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rexec_valid", 32'(rsp_valid), 32'd0);
    chk("rexec_ready", 32'(req_ready), 32'd1);
    chk("rexec_aluop_idle", 32'(alu_opcode), 32'h3F);
    chk("rexec_op_count", 32'(op_count), 32'd0);
    chk("rexec_taken_count", 32'(taken_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rexec_no_rsp", 32'(rsp_valid), 32'd0);

    // ---- SUB after reset: 3 - 5 borrows
    send(6'd2, 32'd3, 32'd5, 32'h600, 32'd0);
    tick();
    chk("sub_valid", 32'(rsp_valid), 32'd1);
    chk("sub_result", rsp_result, 32'hFFFF_FFFE);
    chk("sub_flags", 32'(rsp_flags), 32'b1010);
    chk("sub_illegal", 32'(rsp_illegal), 32'd0);
    consume();
    chk("sub_op_count", 32'(op_count), 32'd1);
    chk("sub_taken_count", 32'(taken_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
